// File: rtl/tag_nios_system_sysid_arbiter_if.sv
// Bus bundle between two Avalon-MM pipelined read masters, the round-robin
// arbiter and the shared 32-bit read-only ID/status slave.
`timescale 1ns/1ps
interface tag_nios_system_sysid_arbiter_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 m0_read;
    logic                 m0_address;
    logic                 m0_waitrequest;
    logic [31:0]          m0_readdata;
    logic                 m0_readdatavalid;
    logic                 m1_read;
    logic                 m1_address;
    logic                 m1_waitrequest;
    logic [31:0]          m1_readdata;
    logic                 m1_readdatavalid;
    logic                 s_address;
    logic [31:0]          s_readdata;
    logic [CNT_WIDTH-1:0] m0_grant_count;
    logic [CNT_WIDTH-1:0] m1_grant_count;

    // Arbiter side
    modport slave (
        input  m0_read, m0_address, m1_read, m1_address, s_readdata,
        output m0_waitrequest, m0_readdata, m0_readdatavalid,
        output m1_waitrequest, m1_readdata, m1_readdatavalid,
        output s_address, m0_grant_count, m1_grant_count
    );

    // Environment side: the two masters plus the shared slave
    modport master (
        output m0_read, m0_address, m1_read, m1_address, s_readdata,
        input  m0_waitrequest, m0_readdata, m0_readdatavalid,
        input  m1_waitrequest, m1_readdata, m1_readdatavalid,
        input  s_address, m0_grant_count, m1_grant_count
    );
endinterface

// File: rtl/tag_nios_system_sysid_arbiter.sv
// Two-master round-robin arbiter in front of a fixed-latency read-only slave.
// At most one read is granted per cycle; a {valid, owner} tag follows each
// grant down a pipeline and steers the returned slave data to its owner.
`timescale 1ns/1ps
module tag_nios_system_sysid_arbiter #(
    parameter int SLAVE_LATENCY = 0,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                              clock,
    input  logic                              reset,
    tag_nios_system_sysid_arbiter_if.slave    bus
);

    if (SLAVE_LATENCY < 0 || SLAVE_LATENCY > 3) begin : g_bad_latency
        $error("SLAVE_LATENCY must be in 0..3");
    end

    typedef struct packed {
        logic vld;
        logic id;
    } tag_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                 last_grant_q, last_grant_d;
    logic                 s_addr_q, s_addr_d;
    logic                 grant0, grant1;
    tag_t                 cur_tag, data_tag;
    logic [31:0]          rd0_q, rd1_q;
    logic                 rdv0_q, rdv1_q;
    logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    // Arbitration, slave address steering and next-state for counters
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (bus.m0_read && (!bus.m1_read || last_grant_q)) begin
                grant0 = 1'b1;
            end else if (bus.m1_read) begin
                grant1 = 1'b1;
            end
        end

        last_grant_d = last_grant_q;
        s_addr_d     = s_addr_q;
        if (grant0) begin
            last_grant_d = 1'b0;
            s_addr_d     = bus.m0_address;
        end else if (grant1) begin
            last_grant_d = 1'b1;
            s_addr_d     = bus.m1_address;
        end

        cur_tag.vld = grant0 | grant1;
        cur_tag.id  = grant1;

        cnt0_d = cnt0_q;
        if (grant0 && cnt0_q != CNT_MAX) begin
            cnt0_d = cnt0_q + 1'b1;
        end
        cnt1_d = cnt1_q;
        if (grant1 && cnt1_q != CNT_MAX) begin
            cnt1_d = cnt1_q + 1'b1;
        end
    end

    // Tag pipeline: stage 0 is the live grant, SLAVE_LATENCY registered stages follow
    if (SLAVE_LATENCY == 0) begin : g_lat0
        always_comb data_tag = cur_tag;
    end else begin : g_pipe
        localparam int TW = 2 * SLAVE_LATENCY;
        tag_t [SLAVE_LATENCY-1:0] tag_q;

        // Shift tags one stage per cycle; reset discards every in-flight read
        always_ff @(posedge clock) begin
            if (reset) begin
                tag_q <= '0;
            end else begin
                tag_q <= TW'({tag_q, cur_tag});
            end
        end

        always_comb data_tag = tag_q[SLAVE_LATENCY-1];
    end

    // Arbiter state, counters and data return to the owning master
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            s_addr_q     <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
            rdv0_q       <= 1'b0;
            rdv1_q       <= 1'b0;
            rd0_q        <= '0;
            rd1_q        <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            s_addr_q     <= s_addr_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
            rdv0_q       <= data_tag.vld & ~data_tag.id;
            rdv1_q       <= data_tag.vld &  data_tag.id;
            if (data_tag.vld && !data_tag.id) begin
                rd0_q <= bus.s_readdata;
            end
            if (data_tag.vld && data_tag.id) begin
                rd1_q <= bus.s_readdata;
            end
        end
    end

    assign bus.m0_waitrequest   = bus.m0_read & ~grant0;
    assign bus.m1_waitrequest   = bus.m1_read & ~grant1;
    assign bus.s_address        = s_addr_d;
    assign bus.m0_readdata      = rd0_q;
    assign bus.m1_readdata      = rd1_q;
    assign bus.m0_readdatavalid = rdv0_q;
    assign bus.m1_readdatavalid = rdv1_q;
    assign bus.m0_grant_count   = cnt0_q;
    assign bus.m1_grant_count   = cnt1_q;

endmodule

// File: tb/tb_tag_nios_system_sysid_arbiter.sv
// Directed bench for the sysid arbiter: three instances cover slave latency
// 0, 2 and 3 and a 2-bit grant counter.
`timescale 1ns/1ps
module tb_tag_nios_system_sysid_arbiter;

    localparam logic [31:0] K = 32'h6073CAF7;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    tag_nios_system_sysid_arbiter_if #(.CNT_WIDTH(16)) bus_a ();
    tag_nios_system_sysid_arbiter_if #(.CNT_WIDTH(16)) bus_b ();
    tag_nios_system_sysid_arbiter_if #(.CNT_WIDTH(2))  bus_c ();

    tag_nios_system_sysid_arbiter #(.SLAVE_LATENCY(0), .CNT_WIDTH(16)) dut_a (
        .clock(clk), .reset(rst_a), .bus(bus_a.slave));
    tag_nios_system_sysid_arbiter #(.SLAVE_LATENCY(2), .CNT_WIDTH(16)) dut_b (
        .clock(clk), .reset(rst_b), .bus(bus_b.slave));
    tag_nios_system_sysid_arbiter #(.SLAVE_LATENCY(3), .CNT_WIDTH(2)) dut_c (
        .clock(clk), .reset(rst_c), .bus(bus_c.slave));

    function automatic logic [31:0] slave_data(input logic a);
        return a ? K : 32'h0;
    endfunction

    // Slave models: data appears SLAVE_LATENCY cycles after the address
    logic [1:0] b_pipe;
    logic [2:0] c_pipe;
    always @(posedge clk) begin
        b_pipe <= {b_pipe[0], bus_b.s_address};
        c_pipe <= {c_pipe[1:0], bus_c.s_address};
    end
    assign bus_a.s_readdata = slave_data(bus_a.s_address);
    assign bus_b.s_readdata = slave_data(b_pipe[1]);
    assign bus_c.s_readdata = slave_data(c_pipe[2]);

    typedef struct {
        logic [4:0]  in;    // rst, m0_read, m0_address, m1_read, m1_address
        logic [2:0]  hs;    // m0_waitrequest, m1_waitrequest, s_address
        logic [1:0]  rdv;   // m0_readdatavalid, m1_readdatavalid
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [15:0] c0;
        logic [15:0] c1;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [4:0] in, input logic [2:0] hs, input logic [1:0] rdv,
                       input logic [31:0] rd0, input logic [31:0] rd1,
                       input logic [15:0] c0, input logic [15:0] c1);
        vec_t v;
        v.in = in; v.hs = hs; v.rdv = rdv; v.rd0 = rd0; v.rd1 = rd1; v.c0 = c0; v.c1 = c1;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus_a.m0_read = 1'b0; bus_a.m0_address = 1'b0; bus_a.m1_read = 1'b0; bus_a.m1_address = 1'b0;
        bus_b.m0_read = 1'b0; bus_b.m0_address = 1'b0; bus_b.m1_read = 1'b0; bus_b.m1_address = 1'b0;
        bus_c.m0_read = 1'b0; bus_c.m0_address = 1'b0; bus_c.m1_read = 1'b0; bus_c.m1_address = 1'b0;
    endtask

    initial begin
        logic addr_seq [4];
        addr_seq = '{1'b1, 1'b0, 1'b1, 1'b1};

        // Latency-0 instance: reset, single read, alternation, lone requester then contention
        add(5'b11110, 3'b110, 2'b00, 32'h0, 32'h0, 16'd0, 16'd0);
        add(5'b01100, 3'b001, 2'b00, 32'h0, 32'h0, 16'd0, 16'd0);
        add(5'b00000, 3'b001, 2'b10, K,     32'h0, 16'd1, 16'd0);
        add(5'b10000, 3'b001, 2'b00, K,     32'h0, 16'd1, 16'd0);
        add(5'b01011, 3'b010, 2'b00, 32'h0, 32'h0, 16'd0, 16'd0);
        add(5'b01011, 3'b101, 2'b10, 32'h0, 32'h0, 16'd1, 16'd0);
        add(5'b01011, 3'b010, 2'b01, 32'h0, K,     16'd1, 16'd1);
        add(5'b01011, 3'b101, 2'b10, 32'h0, K,     16'd2, 16'd1);
        add(5'b01011, 3'b010, 2'b01, 32'h0, K,     16'd2, 16'd2);
        add(5'b01011, 3'b101, 2'b10, 32'h0, K,     16'd3, 16'd2);
        add(5'b00000, 3'b001, 2'b01, 32'h0, K,     16'd3, 16'd3);
        add(5'b01000, 3'b000, 2'b00, 32'h0, K,     16'd3, 16'd3);
        add(5'b01000, 3'b000, 2'b10, 32'h0, K,     16'd4, 16'd3);
        add(5'b01000, 3'b000, 2'b10, 32'h0, K,     16'd5, 16'd3);
        add(5'b01011, 3'b101, 2'b10, 32'h0, K,     16'd6, 16'd3);
        add(5'b01011, 3'b010, 2'b01, 32'h0, K,     16'd6, 16'd4);
        add(5'b00000, 3'b000, 2'b10, 32'h0, K,     16'd7, 16'd4);

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        idle_all();
        tick();
        tick();

        foreach (vq[i]) begin
            tick();
            rst_a            = vq[i].in[4];
            bus_a.m0_read    = vq[i].in[3];
            bus_a.m0_address = vq[i].in[2];
            bus_a.m1_read    = vq[i].in[1];
            bus_a.m1_address = vq[i].in[0];
            #4;
            chk("a_m0_waitrequest",   i, 32'(bus_a.m0_waitrequest),   32'(vq[i].hs[2]));
            chk("a_m1_waitrequest",   i, 32'(bus_a.m1_waitrequest),   32'(vq[i].hs[1]));
            chk("a_s_address",        i, 32'(bus_a.s_address),        32'(vq[i].hs[0]));
            chk("a_m0_readdatavalid", i, 32'(bus_a.m0_readdatavalid), 32'(vq[i].rdv[1]));
            chk("a_m1_readdatavalid", i, 32'(bus_a.m1_readdatavalid), 32'(vq[i].rdv[0]));
            chk("a_m0_readdata",      i, bus_a.m0_readdata,           vq[i].rd0);
            chk("a_m1_readdata",      i, bus_a.m1_readdata,           vq[i].rd1);
            chk("a_m0_grant_count",   i, 32'(bus_a.m0_grant_count),   32'(vq[i].c0));
            chk("a_m1_grant_count",   i, 32'(bus_a.m1_grant_count),   32'(vq[i].c1));
        end

        // Latency 3: four back-to-back m1 reads return in order, 4 cycles after accept
        tick();
        idle_all();
        rst_c = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            bus_c.m1_read    = (k < 4);
            bus_c.m1_address = (k < 4) ? addr_seq[k] : 1'b0;
            #4;
            if (k < 4) chk("c_m1_waitrequest", k, 32'(bus_c.m1_waitrequest), 32'h0);
            chk("c_m1_readdatavalid", k, 32'(bus_c.m1_readdatavalid), 32'((k >= 4) && (k <= 7)));
            chk("c_m0_readdatavalid", k, 32'(bus_c.m0_readdatavalid), 32'h0);
            if (k >= 4 && k <= 7) chk("c_m1_readdata", k, bus_c.m1_readdata, slave_data(addr_seq[k-4]));
        end
        chk("c_m1_grant_count_sat", 0, 32'(bus_c.m1_grant_count), 32'd3);

        // 2-bit counter: five m0 grants saturate at 3
        for (int k = 0; k < 6; k++) begin
            tick();
            bus_c.m0_read    = (k < 5);
            bus_c.m0_address = 1'b0;
            #4;
            chk("c_m0_grant_count", k, 32'(bus_c.m0_grant_count), (k < 3) ? 32'(k) : 32'd3);
        end

        // Latency 2: reset right after two accepted reads kills both returns
        tick();
        rst_b = 1'b0;
        bus_b.m1_read = 1'b1; bus_b.m1_address = 1'b1;
        #4;
        chk("b_m1_waitrequest", 0, 32'(bus_b.m1_waitrequest), 32'h0);
        tick();
        bus_b.m1_read = 1'b0;
        bus_b.m0_read = 1'b1; bus_b.m0_address = 1'b1;
        #4;
        chk("b_m0_waitrequest", 1, 32'(bus_b.m0_waitrequest), 32'h0);
        chk("b_m1_grant_count", 1, 32'(bus_b.m1_grant_count), 32'd1);
        tick();
        rst_b = 1'b1;
        bus_b.m1_read = 1'b1;
        #4;
        chk("b_rst_m0_waitrequest", 2, 32'(bus_b.m0_waitrequest), 32'h1);
        chk("b_rst_m1_waitrequest", 2, 32'(bus_b.m1_waitrequest), 32'h1);
        chk("b_m0_grant_count", 2, 32'(bus_b.m0_grant_count), 32'd1);
        for (int k = 3; k < 9; k++) begin
            tick();
            rst_b = 1'b0;
            bus_b.m0_read = 1'b0;
            bus_b.m1_read = 1'b0;
            #4;
            chk("b_m0_readdatavalid", k, 32'(bus_b.m0_readdatavalid), 32'h0);
            chk("b_m1_readdatavalid", k, 32'(bus_b.m1_readdatavalid), 32'h0);
            if (k == 3) begin
                chk("b_m0_grant_count", k, 32'(bus_b.m0_grant_count), 32'd0);
                chk("b_m1_grant_count", k, 32'(bus_b.m1_grant_count), 32'd0);
            end
        end
        tick();
        bus_b.m0_read = 1'b1; bus_b.m0_address = 1'b0;
        bus_b.m1_read = 1'b1; bus_b.m1_address = 1'b1;
        #4;
        chk("b_post_rst_m0_waitrequest", 9, 32'(bus_b.m0_waitrequest), 32'h0);
        chk("b_post_rst_m1_waitrequest", 9, 32'(bus_b.m1_waitrequest), 32'h1);
        tick();
        bus_b.m0_read = 1'b0;
        #4;
        chk("b_next_m1_waitrequest", 10, 32'(bus_b.m1_waitrequest), 32'h0);
        tick();
        idle_all();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
